// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
// Channel phase storage is compiled in only when CLKDIV_PHASE_EN is defined.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_SYNC    = 2'd1,
    ST_LOCKING = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // A zero divide ratio is meaningless; treat it as divide-by-one.
  function automatic int clamp_div(input int div);
    return (div == 0) ? 1 : div;
  endfunction

  // The phase must be a legal count for the (already clamped) divide ratio.
  function automatic int clamp_phase(input int phase, input int div);
    return (phase >= div) ? div - 1 : phase;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: D/P registers, wrap counter and registered outclk/outclk_en.
// Phase register exists only with CLKDIV_PHASE_EN; otherwise every SYNC loads zero.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             load,
  input  logic             run,
  input  logic             out_en,
  output logic             outclk,
  output logic             outclk_en
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] load_val;
  logic [DIV_W:0]   half;
  logic             outclk_q, outclk_d;
  logic             en_q, en_d;

`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (wr_en) phase_d = DIV_W'(clamp_phase(int'(wr_phase), clamp_div(int'(wr_div))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign load_val = phase_q;
`else
  logic phase_unused;
  assign phase_unused = ^wr_phase;
  assign load_val     = '0;
`endif

  always_comb begin
    div_d = div_q;
    if (wr_en) div_d = DIV_W'(clamp_div(int'(wr_div)));
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (run) cnt_d = (cnt_q == div_q - 1'b1) ? '0 : cnt_q + 1'b1;
    // High for ceil(D/2) counts; outputs are computed from the next count so they are registered.
    half     = ({1'b0, div_q} + 1'b1) >> 1;
    outclk_d = out_en && ({1'b0, cnt_d} < half);
    en_d     = out_en && (cnt_d == div_q - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      en_q     <= en_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = en_q;

endmodule

// File: rtl/clkdiv_multi_gen.sv
// Multi-channel clock-enable generator: lock/sync FSM, lock counter and write decode.
// Define CLKDIV_PHASE_EN to enable per-channel phase offsets.
module clkdiv_multi_gen
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = calc_ch_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           wr_ok;
  logic           load, run, out_en;

  // Handshake: a write is taken on the edge where cfg_wr && cfg_ready; out-of-range channels are dropped.
  assign cfg_ready = (state_q == ST_LOCKING) || (state_q == ST_LOCKED);
  assign wr_ok     = cfg_wr && cfg_ready && (int'(cfg_ch) < NUM_CH);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_RESET: state_d = ST_SYNC;
      ST_SYNC: begin
        state_d    = ST_LOCKING;
        lock_cnt_d = '0;
      end
      ST_LOCKING: begin
        if (wr_ok)                                      state_d = ST_SYNC;
        else if (lock_cnt_q == LCW'(LOCK_CYCLES - 1))   state_d = ST_LOCKED;
        else                                            lock_cnt_d = lock_cnt_q + 1'b1;
      end
      ST_LOCKED: if (wr_ok) state_d = ST_SYNC;
      default: state_d = ST_RESET;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
  assign load   = (state_q == ST_SYNC);
  assign run    = cfg_ready;
  // Channel outputs follow the state being entered, so they are forced low throughout RESET/SYNC.
  assign out_en = (state_d == ST_LOCKING) || (state_d == ST_LOCKED);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (refclk),
      .rst       (rst),
      .wr_en     (wr_ok && (cfg_ch == CH_W'(i))),
      .wr_div    (cfg_div),
      .wr_phase  (cfg_phase),
      .load      (load),
      .run       (run),
      .out_en    (out_en),
      .outclk    (outclk[i]),
      .outclk_en (outclk_en[i])
    );
  end

endmodule
